// File: rtl/disk_image_server_pkg.sv
// Shared definitions for the disk image server: request/response word layout,
// operation codes, controller states and SAM MGT geometry defaults.
package disk_pkg;

    localparam int DEF_SPT          = 10;
    localparam int DEF_TRACKS       = 80;
    localparam int DEF_SECTOR_BYTES = 512;
    localparam int DEF_BYTE_GAP     = 4;
    localparam int DEF_AW           = 21;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    // disk_sr fields
    localparam int SR_OP_HI  = 31;
    localparam int SR_OP_LO  = 30;
    localparam int SR_TOG    = 29;
    localparam int SR_DRIVE  = 28;
    localparam int SR_SIDE   = 27;
    localparam int SR_TRK_HI = 26;
    localparam int SR_TRK_LO = 20;
    localparam int SR_SEC_HI = 19;
    localparam int SR_SEC_LO = 12;

    // disk_cr fields
    localparam int CR_ACK    = 31;
    localparam int CR_ERR    = 30;
    localparam int CR_INS_HI = 29;
    localparam int CR_INS_LO = 28;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CALC,
        ST_RD_MEM,
        ST_RD_PUSH,
        ST_RD_GAP,
        ST_WR_PULL,
        ST_WR_LATCH,
        ST_WR_MEM,
        ST_WR_GAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/disk_image_server_if.sv
// Byte-wide request/acknowledge bus to the disk image store.
// master = the server, slave = the memory side.
interface disk_image_server_if #(
    parameter int AW = disk_pkg::DEF_AW
);
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [7:0]    mem_dout;
    logic [7:0]    mem_din;
    logic          mem_ack;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_dout,
        input  mem_din, mem_ack
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_dout,
        output mem_din, mem_ack
    );
endinterface

// File: rtl/disk_lba_calc.sv
// Sector base address: drive*(2*TRACKS*SPT) + (track*2+side)*SPT + sector-1,
// scaled to bytes. Two registered stages, valid pulses 2 cycles after start.
// sector is assumed already range-checked (>= 1).
module disk_lba_calc
    import disk_pkg::*;
#(
    parameter int SPT          = DEF_SPT,
    parameter int TRACKS       = DEF_TRACKS,
    parameter int SECTOR_BYTES = DEF_SECTOR_BYTES,
    parameter int AW           = DEF_AW
) (
    input  logic          clk24,
    input  logic          rstn,
    input  logic          start,
    input  logic          drive,
    input  logic          side,
    input  logic [6:0]    track,
    input  logic [7:0]    sector,
    output logic [AW-1:0] base,
    output logic          valid
);
    localparam logic [AW-1:0] DRIVE_SECTORS = AW'(2 * TRACKS * SPT);
    localparam logic [AW-1:0] SPT_W         = AW'(SPT);
    localparam int            SHIFT         = $clog2(SECTOR_BYTES);

    logic [AW-1:0] drive_off;
    logic [AW-1:0] trk_sec;
    logic [AW-1:0] sec_idx;
    logic          stage_v;

    // stage 1: per-term products, captured only on start so base stays put
    always_ff @(posedge clk24 or negedge rstn) begin
        if (!rstn) begin
            drive_off <= '0;
            trk_sec   <= '0;
            sec_idx   <= '0;
            stage_v   <= 1'b0;
        end else begin
            stage_v <= start;
            if (start) begin
                drive_off <= drive ? DRIVE_SECTORS : '0;
                trk_sec   <= AW'({track, side}) * SPT_W;
                sec_idx   <= AW'(sector) - AW'(1);
            end
        end
    end

    // stage 2: sum and scale to a byte address
    always_ff @(posedge clk24 or negedge rstn) begin
        if (!rstn) begin
            base  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= stage_v;
            if (stage_v) begin
                base <= (drive_off + trk_sec + sec_idx) << SHIFT;
            end
        end
    end
endmodule

// File: rtl/disk_image_server.sv
// Serves drive sector requests from a flat disk image in external memory.
//
//  state       | meaning
//  ------------+--------------------------------------------------------
//  ST_IDLE     | wait for disk_sr toggle != ack toggle, latch request
//  ST_CHECK    | validate sector/track/insertion
//  ST_CALC     | wait for base address from disk_lba_calc
//  ST_RD_MEM   | mem_rd held until mem_ack
//  ST_RD_PUSH  | disk_data_clkin high with fetched byte
//  ST_RD_GAP   | hold off until byte gap expires, loop or finish
//  ST_WR_PULL  | disk_data_clkout high
//  ST_WR_LATCH | sample disk_data_out, launch mem_wr
//  ST_WR_MEM   | mem_wr held until mem_ack
//  ST_WR_GAP   | hold off until byte gap expires, loop or finish
//  ST_DONE     | publish error and ack toggle together
module disk_image_server
    import disk_pkg::*;
#(
    parameter int SPT          = DEF_SPT,
    parameter int TRACKS       = DEF_TRACKS,
    parameter int SECTOR_BYTES = DEF_SECTOR_BYTES,
    parameter int BYTE_GAP     = DEF_BYTE_GAP,
    parameter int AW           = DEF_AW
) (
    input  logic                 clk24,
    input  logic                 rstn,
    input  logic [31:0]          disk_sr,
    output logic [31:0]          disk_cr,
    output logic [7:0]           disk_data_in,
    output logic                 disk_data_clkin,
    input  logic [7:0]           disk_data_out,
    output logic                 disk_data_clkout,
    input  logic [1:0]           disk_inserted,
    disk_image_server_if.master  mem
);
    localparam int            CW       = $clog2(SECTOR_BYTES) + 1;
    localparam int            GW       = $clog2(BYTE_GAP) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SECTOR_BYTES);
    localparam logic [GW-1:0] GAP_LOAD = GW'(BYTE_GAP - 1);

    state_t        state;
    op_t           op_q;
    logic          tog_q;
    logic          drive_q;
    logic          side_q;
    logic [6:0]    track_q;
    logic [7:0]    sector_q;
    logic          err_q;
    logic          ack_tog;
    logic          cr_err;
    logic [1:0]    ins_q;
    logic [CW-1:0] count;
    logic [GW-1:0] gap_cnt;
    logic          calc_start;
    logic [AW-1:0] lba_base;
    logic          lba_valid;
    logic [AW-1:0] mem_addr_q;
    logic          mem_rd_q;
    logic          mem_wr_q;
    logic [7:0]    mem_dout_q;
    logic          bad_req;
    logic          unused_sr;

    assign unused_sr = ^disk_sr[SR_SEC_LO-1:0];

    assign disk_cr = {ack_tog, cr_err, ins_q, 28'h0};

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_rd   = mem_rd_q;
    assign mem.mem_wr   = mem_wr_q;
    assign mem.mem_dout = mem_dout_q;

    // request validity, evaluated on the latched fields
    always_comb begin
        bad_req = (sector_q == 8'd0)
               || (sector_q > 8'(SPT))
               || ({1'b0, track_q} >= 8'(TRACKS))
               || !disk_inserted[drive_q];
    end

    disk_lba_calc #(
        .SPT          (SPT),
        .TRACKS       (TRACKS),
        .SECTOR_BYTES (SECTOR_BYTES),
        .AW           (AW)
    ) u_lba (
        .clk24  (clk24),
        .rstn   (rstn),
        .start  (calc_start),
        .drive  (drive_q),
        .side   (side_q),
        .track  (track_q),
        .sector (sector_q),
        .base   (lba_base),
        .valid  (lba_valid)
    );

    // insertion mask mirrored into the response word every cycle
    always_ff @(posedge clk24 or negedge rstn) begin
        if (!rstn) begin
            ins_q <= 2'b00;
        end else begin
            ins_q <= disk_inserted;
        end
    end

    // request sequencer; gap timer is loaded on every drive-side strobe
    always_ff @(posedge clk24 or negedge rstn) begin
        if (!rstn) begin
            state            <= ST_IDLE;
            op_q             <= OP_IDLE;
            tog_q            <= 1'b0;
            drive_q          <= 1'b0;
            side_q           <= 1'b0;
            track_q          <= '0;
            sector_q         <= '0;
            err_q            <= 1'b0;
            ack_tog          <= 1'b0;
            cr_err           <= 1'b0;
            count            <= '0;
            gap_cnt          <= '0;
            calc_start       <= 1'b0;
            mem_addr_q       <= '0;
            mem_rd_q         <= 1'b0;
            mem_wr_q         <= 1'b0;
            mem_dout_q       <= '0;
            disk_data_in     <= '0;
            disk_data_clkin  <= 1'b0;
            disk_data_clkout <= 1'b0;
        end else begin
            calc_start <= 1'b0;
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (disk_sr[SR_TOG] != ack_tog) begin
                        tog_q    <= disk_sr[SR_TOG];
                        op_q     <= op_t'(disk_sr[SR_OP_HI:SR_OP_LO]);
                        drive_q  <= disk_sr[SR_DRIVE];
                        side_q   <= disk_sr[SR_SIDE];
                        track_q  <= disk_sr[SR_TRK_HI:SR_TRK_LO];
                        sector_q <= disk_sr[SR_SEC_HI:SR_SEC_LO];
                        err_q    <= 1'b0;
                        if (disk_sr[SR_OP_HI:SR_OP_LO] == OP_READ ||
                            disk_sr[SR_OP_HI:SR_OP_LO] == OP_WRITE) begin
                            state <= ST_CHECK;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_CHECK: begin
                    if (bad_req) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        calc_start <= 1'b1;
                        count      <= '0;
                        state      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (lba_valid) begin
                        if (op_q == OP_READ) begin
                            mem_addr_q <= lba_base;
                            mem_rd_q   <= 1'b1;
                            state      <= ST_RD_MEM;
                        end else begin
                            disk_data_clkout <= 1'b1;
                            gap_cnt          <= GAP_LOAD;
                            state            <= ST_WR_PULL;
                        end
                    end
                end
                ST_RD_MEM: begin
                    if (mem.mem_ack) begin
                        mem_rd_q        <= 1'b0;
                        disk_data_in    <= mem.mem_din;
                        disk_data_clkin <= 1'b1;
                        gap_cnt         <= GAP_LOAD;
                        state           <= ST_RD_PUSH;
                    end
                end
                ST_RD_PUSH: begin
                    disk_data_clkin <= 1'b0;
                    count           <= count + 1'b1;
                    state           <= ST_RD_GAP;
                end
                ST_RD_GAP: begin
                    if (gap_cnt == '0) begin
                        if (count == LAST_CNT) begin
                            state <= ST_DONE;
                        end else begin
                            mem_addr_q <= lba_base + AW'(count);
                            mem_rd_q   <= 1'b1;
                            state      <= ST_RD_MEM;
                        end
                    end
                end
                ST_WR_PULL: begin
                    disk_data_clkout <= 1'b0;
                    state            <= ST_WR_LATCH;
                end
                ST_WR_LATCH: begin
                    mem_dout_q <= disk_data_out;
                    mem_addr_q <= lba_base + AW'(count);
                    mem_wr_q   <= 1'b1;
                    state      <= ST_WR_MEM;
                end
                ST_WR_MEM: begin
                    if (mem.mem_ack) begin
                        mem_wr_q <= 1'b0;
                        count    <= count + 1'b1;
                        state    <= ST_WR_GAP;
                    end
                end
                ST_WR_GAP: begin
                    if (gap_cnt == '0) begin
                        if (count == LAST_CNT) begin
                            state <= ST_DONE;
                        end else begin
                            disk_data_clkout <= 1'b1;
                            gap_cnt          <= GAP_LOAD;
                            state            <= ST_WR_PULL;
                        end
                    end
                end
                ST_DONE: begin
                    cr_err  <= err_q;
                    ack_tog <= tog_q;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_disk_image_server.sv
// Directed bench for disk_image_server: memory and drive-buffer models,
// a negedge monitor that scores strobes and memory traffic, and per-test checks.
module tb_disk_image_server;
    import disk_pkg::*;

    logic        clk24 = 1'b0;
    logic        rstn  = 1'b0;
    logic [31:0] disk_sr = '0;
    logic [31:0] disk_cr;
    logic [7:0]  disk_data_in;
    logic        disk_data_clkin;
    logic [7:0]  disk_data_out;
    logic        disk_data_clkout;
    logic [1:0]  disk_inserted = 2'b11;

    disk_image_server_if mem ();

    disk_image_server dut (
        .clk24            (clk24),
        .rstn             (rstn),
        .disk_sr          (disk_sr),
        .disk_cr          (disk_cr),
        .disk_data_in     (disk_data_in),
        .disk_data_clkin  (disk_data_clkin),
        .disk_data_out    (disk_data_out),
        .disk_data_clkout (disk_data_clkout),
        .disk_inserted    (disk_inserted),
        .mem              (mem)
    );

    always #5 clk24 = ~clk24;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_val(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_pat(input logic [20:0] a);
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5a;
    endfunction

    function automatic logic [7:0] drv_pat(input int k);
        return 8'((k * 7 + 3) & 255);
    endfunction

    // expected byte address of the k-th transfer, possibly spanning two requests
    longint base_a = 0;
    longint base_b = 0;
    function automatic longint exp_addr(input int k);
        return (k < 512) ? base_a + k : base_b + (k - 512);
    endfunction

    // monitor counters
    logic   clr = 1'b1;
    int     cyc = 0;
    int     last_strb = -100;
    int     n_clkin, n_pull, n_rd, n_wr, n_ack;
    int     e_data, e_addr, e_gap, e_both;
    longint first_wr;
    logic   prev_ack;

    // memory model: acknowledges each held request after one cycle
    always @(posedge clk24) begin
        if (!rstn) begin
            mem.mem_ack <= 1'b0;
            mem.mem_din <= 8'h00;
        end else begin
            mem.mem_ack <= 1'b0;
            if ((mem.mem_rd || mem.mem_wr) && !mem.mem_ack) begin
                mem.mem_ack <= 1'b1;
                mem.mem_din <= mem_pat(mem.mem_addr);
            end
        end
    end

    // drive buffer model: presents byte k after the k-th clkout pulse
    always @(posedge clk24) begin
        if (!rstn) begin
            disk_data_out <= 8'h00;
        end else if (disk_data_clkout) begin
            disk_data_out <= drv_pat(n_pull - 1);
        end
    end

    // scoreboard monitor
    always @(negedge clk24) begin
        cyc++;
        if (clr) begin
            n_clkin = 0; n_pull = 0; n_rd = 0; n_wr = 0; n_ack = 0;
            e_data = 0; e_addr = 0; e_gap = 0; e_both = 0;
            first_wr = -1; last_strb = -100;
            prev_ack = disk_cr[CR_ACK];
        end else begin
            if (disk_data_clkin && disk_data_clkout) e_both++;
            if (mem.mem_rd && mem.mem_wr) e_both++;
            if (disk_data_clkin || disk_data_clkout) begin
                if (cyc - last_strb < DEF_BYTE_GAP) e_gap++;
                last_strb = cyc;
            end
            if (disk_data_clkin) begin
                if (disk_data_in != mem_pat(21'(exp_addr(n_clkin)))) e_data++;
                n_clkin++;
            end
            if (disk_data_clkout) n_pull++;
            if (mem.mem_ack && mem.mem_rd) begin
                if (longint'(mem.mem_addr) != exp_addr(n_rd)) e_addr++;
                n_rd++;
            end
            if (mem.mem_ack && mem.mem_wr) begin
                if (n_wr == 0) first_wr = longint'(mem.mem_addr);
                if (longint'(mem.mem_addr) != exp_addr(n_wr)) e_addr++;
                if (mem.mem_dout != drv_pat(n_wr)) e_data++;
                n_wr++;
            end
            if (disk_cr[CR_ACK] != prev_ack) n_ack++;
            prev_ack = disk_cr[CR_ACK];
        end
    end

    logic tog = 1'b0;

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk24);
        #1;
        clr = 1'b0;
    endtask

    task automatic post(input logic [1:0] op, input logic drive, input logic side,
                        input int track, input int sector);
        tog = ~tog;
        disk_sr = {op, tog, drive, side, 7'(track), 8'(sector), 12'h000};
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int n = 0;
        while (disk_cr[CR_ACK] != tog && n < budget) begin
            @(negedge clk24);
            n++;
        end
        chk_val({tag, "_ack"}, disk_cr[CR_ACK], tog);
    endtask

    task automatic wait_strobes(input string tag, input int target, input int budget);
        int n = 0;
        while (n_clkin < target && n < budget) begin
            @(negedge clk24);
            n++;
        end
        chk_val({tag, "_reach"}, (n_clkin >= target) ? 1 : 0, 1);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk24);
        chk_val("rst_cr", disk_cr, 0);
        chk_val("rst_mem_rd", mem.mem_rd, 0);
        chk_val("rst_clkin", disk_data_clkin, 0);
        chk_val("rst_clkout", disk_data_clkout, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk24);
        chk_val("ins_mask", disk_cr, 32'h3000_0000);

        // read drive 1, side 0, track 0, sector 1
        clear_mon();
        base_a = 0;
        post(OP_READ, 1'b0, 1'b0, 0, 1);
        wait_ack("t1", 10000);
        chk_val("t1_err", disk_cr[CR_ERR], 0);
        chk_val("t1_strobes", n_clkin, 512);
        chk_val("t1_memrd", n_rd, 512);
        chk_val("t1_data", e_data, 0);
        chk_val("t1_addr", e_addr, 0);
        chk_val("t1_gap", e_gap, 0);
        chk_val("t1_both", e_both, 0);

        // write drive 2, side 1, track 79, sector 10
        clear_mon();
        base_a = 1637888;
        post(OP_WRITE, 1'b1, 1'b1, 79, 10);
        wait_ack("t2", 10000);
        chk_val("t2_err", disk_cr[CR_ERR], 0);
        chk_val("t2_first", first_wr, 1637888);
        chk_val("t2_pulls", n_pull, 512);
        chk_val("t2_memwr", n_wr, 512);
        chk_val("t2_data", e_data, 0);
        chk_val("t2_addr", e_addr, 0);
        chk_val("t2_gap", e_gap, 0);
        chk_val("t2_both", e_both, 0);

        // sector out of range: 11 then 0, plus track 80
        clear_mon();
        post(OP_READ, 1'b0, 1'b0, 0, 11);
        wait_ack("s11", 100);
        chk_val("s11_err", disk_cr[CR_ERR], 1);
        post(OP_READ, 1'b0, 1'b0, 0, 0);
        wait_ack("s0", 100);
        chk_val("s0_err", disk_cr[CR_ERR], 1);
        post(OP_READ, 1'b0, 1'b0, 80, 1);
        wait_ack("t80", 100);
        chk_val("t80_err", disk_cr[CR_ERR], 1);
        chk_val("bad_strobes", n_clkin, 0);
        chk_val("bad_mem", n_rd + n_wr, 0);

        // reserved op acknowledged without error or data movement
        post(OP_RSVD, 1'b0, 1'b0, 0, 1);
        wait_ack("rsvd", 100);
        chk_val("rsvd_err", disk_cr[CR_ERR], 0);
        chk_val("rsvd_mem", n_rd + n_wr, 0);

        // drive 2 not inserted
        disk_inserted = 2'b01;
        post(OP_READ, 1'b1, 1'b0, 0, 1);
        wait_ack("noins", 100);
        chk_val("noins_err", disk_cr[CR_ERR], 1);
        chk_val("noins_mask", disk_cr[CR_INS_HI:CR_INS_LO], 2'b01);
        chk_val("noins_strobes", n_clkin, 0);
        disk_inserted = 2'b11;

        // second toggle posted mid-read is served back-to-back
        clear_mon();
        base_a = 10752;
        base_b = 1024;
        post(OP_READ, 1'b0, 1'b0, 1, 2);
        wait_strobes("b2b", 100, 5000);
        post(OP_READ, 1'b0, 1'b0, 0, 3);
        begin
            int n = 0;
            while (n_ack < 2 && n < 20000) begin
                @(negedge clk24);
                n++;
            end
        end
        chk_val("b2b_acks", n_ack, 2);
        chk_val("b2b_final_ack", disk_cr[CR_ACK], tog);
        chk_val("b2b_strobes", n_clkin, 1024);
        chk_val("b2b_memrd", n_rd, 1024);
        chk_val("b2b_data", e_data, 0);
        chk_val("b2b_addr", e_addr, 0);
        chk_val("b2b_gap", e_gap, 0);

        // reset at byte 200 of a read
        clear_mon();
        base_a = 873472;
        post(OP_READ, 1'b1, 1'b0, 5, 7);
        wait_strobes("rst200", 200, 5000);
        chk_val("rst200_data", e_data, 0);
        #1;
        rstn = 1'b0;
        #1;
        chk_val("rst200_cr", disk_cr, 0);
        chk_val("rst200_rd", mem.mem_rd, 0);
        chk_val("rst200_addr", mem.mem_addr, 0);
        chk_val("rst200_clkin", disk_data_clkin, 0);
        chk_val("rst200_din", disk_data_in, 0);
        disk_sr = '0;
        tog = 1'b0;
        repeat (3) @(negedge clk24);
        rstn = 1'b1;
        clear_mon();
        base_a = 27136;
        post(OP_READ, 1'b0, 1'b1, 2, 4);
        wait_ack("fresh", 10000);
        chk_val("fresh_err", disk_cr[CR_ERR], 0);
        chk_val("fresh_strobes", n_clkin, 512);
        chk_val("fresh_data", e_data, 0);
        chk_val("fresh_addr", e_addr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/disk_image_server.md
Name: disk_image_server

Overview:
- Controller-side responder for the disk status/control interface of the SAM floppy subsystem.
- Replaces the software ctrl-module: decodes sector requests posted on disk_sr and serves them from a flat disk-image store in external memory (SDRAM/BRAM).
- Reads: fetches 512 bytes from the store and strobes them into the drives' sector buffer.
- Writes: pulls 512 bytes from the drives' buffer and commits them to the store.
- Acknowledges each request on disk_cr.

Parameters:
- SPT, 10, sectors per track (sectors numbered 1..SPT).
- TRACKS, 80, tracks per side.
- SECTOR_BYTES, 512, bytes per sector (power of two).
- BYTE_GAP, 4, minimum clk24 cycles between successive byte strobes on the drive side.
- AW, 21, memory byte-address width.

Ports:
- clk24  in  1  system clock; all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- disk_sr  in  32  request word from drives.
  - [31:30] op: 00 idle, 01 read, 10 write, 11 reserved.
  - [29] request toggle.
  - [28] drive (0 = drive 1, 1 = drive 2).
  - [27] side.
  - [26:20] track.
  - [19:12] sector.
- disk_cr  out  32  response word.
  - [31] ack toggle.
  - [30] error.
  - [29:28] inserted mask.
  - Other bits 0.
- disk_data_in  out  8  byte sent to drive buffer.
- disk_data_clkin  out  1  one-cycle strobe qualifying disk_data_in.
- disk_data_out  in  8  byte from drive buffer.
- disk_data_clkout  out  1  one-cycle strobe requesting next byte from drive buffer.
- disk_inserted  in  2  per-drive image present.
- mem_addr  out  AW  byte address.
- mem_rd  out  1  read request, held until mem_ack.
- mem_wr  out  1  write request, held until mem_ack.
- mem_dout  out  8  write data.
- mem_din  in  8  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion.

Behaviour:
- Reset (async, rstn low): all outputs 0, FSM in IDLE, internal ack toggle 0, byte counter 0. disk_cr[29:28] is registered from disk_inserted every cycle after reset release.
- IDLE: a new request is disk_sr[29] != ack toggle AND op in {01,10}.
  - On a new request, latch op, drive, side, track and sector (one cycle), then go to CHECK.
  - A toggle change with op 00 or 11 is acknowledged immediately with error=0 and no data movement.
- CHECK: error if any of:
  - sector == 0;
  - sector > SPT;
  - track >= TRACKS;
  - disk_inserted[drive] == 0.
  - Error: go to DONE with error=1.
  - Otherwise go to CALC.
- CALC: base = drive*(2*TRACKS*SPT*SECTOR_BYTES) + ((track*2+side)*SPT + sector-1)*SECTOR_BYTES.
  - Computed over at most 2 registered cycles, unsigned, AW bits, no wrap: 2*819200 < 2^21.
  - Byte counter cleared.
- Read path:
  - RD_MEM: assert mem_rd with mem_addr = base + count; hold until mem_ack.
  - RD_PUSH: drive disk_data_in = captured mem_din and pulse disk_data_clkin for exactly 1 cycle; count++.
  - RD_GAP: wait until BYTE_GAP cycles have elapsed since the strobe.
  - Loop until count == SECTOR_BYTES, then DONE.
- Write path:
  - WR_PULL: pulse disk_data_clkout for 1 cycle.
  - WR_LATCH: sample disk_data_out on the cycle after the pulse.
  - WR_MEM: assert mem_wr with mem_dout = sampled byte and mem_addr = base + count until mem_ack; count++.
  - Gap rule as for reads. Loop to SECTOR_BYTES, then DONE.
- DONE (1 cycle): disk_cr[30] = error, then disk_cr[31] = latched request toggle. Return to IDLE.
  - Error bit is stable from the same cycle the ack toggles, until the next ack.
- Strobe rules: disk_data_clkin and disk_data_clkout are never high in the same cycle and never on consecutive cycles.
- Requests arriving while busy: disk_sr changes are ignored until IDLE. A toggle still pending on return to IDLE is served next.
- disk_inserted falling mid-transfer: the current sector completes normally; it is checked only in CHECK.
- mem_rd and mem_wr are never asserted together. mem_ack outside RD_MEM/WR_MEM is ignored.
- Async reset mid-transfer: aborts the transfer and clears the ack toggle to 0. The drive side re-synchronises by re-issuing its toggle.

Decomposition:
- Shared package disk_pkg:
  - op encodings and disk_sr/disk_cr bit positions;
  - FSM state enum;
  - SAM MGT geometry defaults.
- One sub-module: disk_lba_calc, which takes drive/side/track/sector and produces a registered base address with a fixed 2-cycle latency and a valid output.

Test Plan:
- Read, drive 1, side 0, track 0, sector 1 → mem_addr 0..511. 512 clkin strobes ≥4 cycles apart carrying the memory pattern. disk_cr[31] toggles, [30]=0.
- Write, drive 2, side 1, track 79, sector 10 → base = 819200 + (159*10+9)*512 = 1637888. 512 clkout pulses; mem_wr data equals the drive-side bytes; ack toggles.
- Sector 11 read (and separately sector 0) → zero strobes, zero mem accesses, disk_cr[30]=1 with toggled ack.
- Read with disk_inserted = 2'b01 targeting drive 2 → error ack, no strobes; disk_cr[29:28] reads 2'b01.
- Second toggle posted mid-read → first read completes (512 strobes), then the second request is served back-to-back; ack toggles twice.
- rstn pulled low at byte 200 of a read → all outputs 0 immediately, mem_rd drops. After release, a fresh request completes a full 512 bytes.
